// File: rtl/rf_read_arbiter_if.sv
// rf_read_arbiter_if: bus bundle between the requesting units, the read arbiter and the
// shared 16x32 register read mux.
//
//   req_valid  per-requester read request
//   req_addr   packed request addresses, requester i at [i*AW +: AW]
//   req_ready  one-hot grant back to the requesters
//   hold       CPU pipeline stall, blocks new grants only
//   mux_sel    select driven into the register read mux
//   mux_y      read data coming back from the register read mux
//   rsp_valid  one-hot response strobe to the granted requester
//   rsp_data   registered read data
//   busy       arbiter pipeline occupied
//
// master: the requesters plus the mux (drives requests and mux data).
// slave:  the arbiter itself.
interface rf_read_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 32
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ-1:0]    req_ready;
    logic                hold;
    logic [AW-1:0]       mux_sel;
    logic [DW-1:0]       mux_y;
    logic [N_REQ-1:0]    rsp_valid;
    logic [DW-1:0]       rsp_data;
    logic                busy;

    modport master (
        output req_valid, req_addr, hold, mux_y,
        input  req_ready, mux_sel, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_addr, hold, mux_y,
        output req_ready, mux_sel, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter: round-robin arbiter sharing one register read mux among N_REQ requesters.
//
// A request is accepted on the edge where req_valid & req_ready; the address is loaded into
// the mux select register (stage A). One edge later the mux output is captured into rsp_data
// and a one-cycle one-hot rsp_valid pulse is issued to the requester that was granted
// (stage B). One accept per cycle, responses come back in accept order.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    rf_read_arbiter_if.slave: request handshake, hold, mux select/data, responses, busy
module rf_read_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 32
) (
    input logic              clk,
    input logic              rst_n,
    rf_read_arbiter_if.slave bus
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IW-1:0]    rr_ptr;
    logic             a_vld;
    logic [IW-1:0]    a_id;

    logic             gnt_any;
    logic [IW-1:0]    gnt_id;
    logic [IW-1:0]    scan_idx;
    logic [N_REQ-1:0] gnt_oh;
    logic [N_REQ-1:0] a_oh;
    logic [AW-1:0]    gnt_addr;

    // Scan from rr_ptr upward with wrap; the first valid requester wins. Gated by rst_n so no
    // grant is presented while reset is asserted.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_id   = '0;
        scan_idx = '0;
        if (rst_n && !bus.hold) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                scan_idx = IW'((32'(rr_ptr) + k) % N_REQ);
                if (!gnt_any && bus.req_valid[scan_idx]) begin
                    gnt_any = 1'b1;
                    gnt_id  = scan_idx;
                end
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (gnt_any) begin
            gnt_oh[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        a_oh       = '0;
        a_oh[a_id] = 1'b1;
    end

    assign gnt_addr      = bus.req_addr[gnt_id*AW +: AW];
    assign bus.req_ready = gnt_oh;
    assign bus.busy      = a_vld | (|bus.rsp_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            a_vld         <= 1'b0;
            a_id          <= '0;
            bus.mux_sel   <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
        end else begin
            // Stage A: mux_sel only moves on an accept so the mux input stays quiet otherwise.
            a_vld <= gnt_any;
            if (gnt_any) begin
                a_id        <= gnt_id;
                bus.mux_sel <= gnt_addr;
                rr_ptr      <= IW'((32'(gnt_id) + 1) % N_REQ);
            end
            // Stage B: capture the mux output for the entry that was in stage A.
            if (a_vld) begin
                bus.rsp_valid <= a_oh;
                bus.rsp_data  <= bus.mux_y;
            end else begin
                bus.rsp_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Bench for rf_read_arbiter. The mux is modelled as Y = sel * 32'h11111111. The reference
// model tracks the round-robin pointer and a queue of pending responses, each tagged with the
// cycle in which its rsp_valid pulse must be visible.
module tb_rf_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_read_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

    rf_read_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    assign bus.mux_y = DW'(bus.mux_sel) * 32'h11111111;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state
    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } ent_t;
    ent_t        q[$];
    int          m_rr;
    logic [3:0]  m_sel;
    logic [31:0] m_last;

    // Per-cycle observed and expected values
    logic [3:0]  obs_ready, exp_ready;
    logic [3:0]  obs_rsp_valid, exp_rsp_valid;
    logic [31:0] obs_rsp_data, exp_rsp_data;
    logic        obs_busy, exp_busy;
    logic [3:0]  obs_mux_sel, exp_mux_sel;

    task automatic model_reset();
        q.delete();
        m_rr   = 0;
        m_sel  = '0;
        m_last = '0;
    endtask

    // Drive one cycle of inputs, sample DUT and model, then advance through the rising edge.
    task automatic cycle(input logic [3:0] v, input logic [15:0] a, input logic h);
        int grant;
        int idx;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.hold      = h;
        #1;
        obs_ready     = bus.req_ready;
        obs_rsp_valid = bus.rsp_valid;
        obs_rsp_data  = bus.rsp_data;
        obs_busy      = bus.busy;
        obs_mux_sel   = bus.mux_sel;

        grant = -1;
        if (!h) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (grant < 0 && v[idx]) grant = idx;
            end
        end
        exp_ready = (grant >= 0) ? (4'b0001 << grant) : 4'b0000;

        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        exp_rsp_valid = '0;
        exp_busy      = 1'b0;
        foreach (q[i]) begin
            if (q[i].due == cyc) begin
                exp_rsp_valid = 4'b0001 << q[i].id;
                m_last        = q[i].data;
                exp_busy      = 1'b1;
            end
            if (q[i].due == cyc + 1) exp_busy = 1'b1;
        end
        exp_rsp_data = m_last;
        exp_mux_sel  = m_sel;

        if (grant >= 0) begin
            q.push_back('{due: cyc + 2, id: grant,
                          data: {28'b0, a[grant*4 +: 4]} * 32'h11111111});
            m_sel = a[grant*4 +: 4];
            m_rr  = (grant + 1) % N;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.hold      = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_addr  = 16'h4321;
        bus.hold      = 1'b0;
        #12;
        checks += 5;
        if (bus.req_ready !== 4'b0000) begin
            failures++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready);
        end
        if (bus.mux_sel !== 4'h0) begin
            failures++; $display("FAIL reset_mux_sel got=%h exp=0", bus.mux_sel);
        end
        if (bus.rsp_valid !== 4'b0000) begin
            failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", bus.rsp_valid);
        end
        if (bus.rsp_data !== 32'h0) begin
            failures++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data);
        end
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        cycle(4'b0001, 16'h0005, 1'b0);
        checks++;
        if (obs_ready !== 4'b0001) begin
            failures++; $display("FAIL single_ready got=%b exp=0001", obs_ready);
        end
        cycle(4'b0000, 16'h0000, 1'b0);
        checks += 3;
        if (obs_mux_sel !== 4'h5) begin
            failures++; $display("FAIL single_mux_sel got=%h exp=5", obs_mux_sel);
        end
        if (obs_rsp_valid !== 4'b0000) begin
            failures++; $display("FAIL single_early_rsp got=%b exp=0000", obs_rsp_valid);
        end
        if (obs_busy !== 1'b1) begin
            failures++; $display("FAIL single_busy_a got=%b exp=1", obs_busy);
        end
        cycle(4'b0000, 16'h0000, 1'b0);
        checks += 2;
        if (obs_rsp_valid !== 4'b0001) begin
            failures++; $display("FAIL single_rsp_valid got=%b exp=0001", obs_rsp_valid);
        end
        if (obs_rsp_data !== 32'h55555555) begin
            failures++; $display("FAIL single_rsp_data got=%h exp=55555555", obs_rsp_data);
        end
        cycle(4'b0000, 16'h0000, 1'b0);
        checks += 3;
        if (obs_busy !== 1'b0) begin
            failures++; $display("FAIL single_busy_clear got=%b exp=0", obs_busy);
        end
        if (obs_rsp_valid !== 4'b0000) begin
            failures++; $display("FAIL single_rsp_pulse got=%b exp=0000", obs_rsp_valid);
        end
        if (obs_rsp_data !== 32'h55555555) begin
            failures++; $display("FAIL single_rsp_hold got=%h exp=55555555", obs_rsp_data);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  g_exp;
        logic [31:0] d_exp;
        do_reset();
        // addrs: requester i -> i+1
        for (int c = 0; c < 10; c++) begin
            cycle(4'b1111, 16'h4321, 1'b0);
            g_exp = 4'b0001 << (c % 4);
            checks++;
            if (obs_ready !== g_exp) begin
                failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, obs_ready, g_exp);
            end
            if (c >= 2) begin
                g_exp = 4'b0001 << ((c - 2) % 4);
                d_exp = 32'(((c - 2) % 4) + 1) * 32'h11111111;
                checks += 2;
                if (obs_rsp_valid !== g_exp) begin
                    failures++;
                    $display("FAIL rr_rsp_valid c=%0d got=%b exp=%b", c, obs_rsp_valid, g_exp);
                end
                if (obs_rsp_data !== d_exp) begin
                    failures++;
                    $display("FAIL rr_rsp_data c=%0d got=%h exp=%h", c, obs_rsp_data, d_exp);
                end
            end
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        cycle(4'b0100, 16'h0A00, 1'b0);  // grant 2, pointer -> 3
        cycle(4'b0101, 16'h0B0C, 1'b0);
        checks++;
        if (obs_ready !== 4'b0001) begin
            failures++; $display("FAIL wrap_first got=%b exp=0001", obs_ready);
        end
        cycle(4'b0101, 16'h0B0C, 1'b0);
        checks++;
        if (obs_ready !== 4'b0100) begin
            failures++; $display("FAIL wrap_second got=%b exp=0100", obs_ready);
        end
        cycle(4'b0101, 16'h0B0C, 1'b0);
        checks += 2;
        if (obs_ready !== 4'b0001) begin
            failures++; $display("FAIL wrap_third got=%b exp=0001", obs_ready);
        end
        if (obs_rsp_valid !== 4'b0001 || obs_rsp_data !== 32'hCCCCCCCC) begin
            failures++;
            $display("FAIL wrap_rsp got=%b/%h exp=0001/cccccccc", obs_rsp_valid, obs_rsp_data);
        end
    endtask

    task automatic test_hold();
        int pulses;
        do_reset();
        cycle(4'b0010, 16'h00E0, 1'b0);  // accept requester 1, addr 0xE
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            cycle(4'b1111, 16'h4321, 1'b1);
            checks += 3;
            if (obs_ready !== 4'b0000) begin
                failures++; $display("FAIL hold_ready c=%0d got=%b exp=0000", c, obs_ready);
            end
            if (obs_mux_sel !== 4'hE) begin
                failures++; $display("FAIL hold_mux_sel c=%0d got=%h exp=e", c, obs_mux_sel);
            end
            if (obs_rsp_valid !== exp_rsp_valid) begin
                failures++;
                $display("FAIL hold_rsp c=%0d got=%b exp=%b", c, obs_rsp_valid, exp_rsp_valid);
            end
            if (obs_rsp_valid == 4'b0010) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            failures++; $display("FAIL hold_pulses got=%0d exp=1", pulses);
        end
        cycle(4'b1111, 16'h4321, 1'b0);
        checks++;
        if (obs_ready !== 4'b0100) begin
            failures++; $display("FAIL hold_resume got=%b exp=0100", obs_ready);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(4'b1000, 16'h7000, 1'b0);  // accept requester 3
        cycle(4'b0100, 16'h0900, 1'b0);  // accept requester 2; in stage A now
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.mux_sel !== 4'h0) begin
            failures++; $display("FAIL areset_mux_sel got=%h exp=0", bus.mux_sel);
        end
        if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL areset_clear got=%b/%b exp=0000/0", bus.rsp_valid, bus.busy);
        end
        if (bus.req_ready !== 4'b0000) begin
            failures++; $display("FAIL areset_ready got=%b exp=0000", bus.req_ready);
        end
        #1 rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            cycle(4'b0000, 16'h0000, 1'b0);
            checks++;
            if (obs_rsp_valid !== 4'b0000 || obs_busy !== 1'b0) begin
                failures++;
                $display("FAIL areset_ghost c=%0d got=%b/%b exp=0000/0", c, obs_rsp_valid, obs_busy);
            end
        end
        cycle(4'b1111, 16'h4321, 1'b0);
        checks++;
        if (obs_ready !== 4'b0001) begin
            failures++; $display("FAIL areset_first_grant got=%b exp=0001", obs_ready);
        end
    endtask

    task automatic test_withdrawn();
        do_reset();
        cycle(4'b0100, 16'h0300, 1'b1);
        checks++;
        if (obs_ready !== 4'b0000) begin
            failures++; $display("FAIL withdraw_ready got=%b exp=0000", obs_ready);
        end
        for (int c = 0; c < 4; c++) begin
            cycle(4'b0000, 16'h0000, 1'b0);
            checks++;
            if (obs_rsp_valid !== 4'b0000 || obs_busy !== 1'b0 || obs_ready !== 4'b0000) begin
                failures++;
                $display("FAIL withdraw_quiet c=%0d got=%b/%b/%b exp=0000/0/0000",
                         c, obs_rsp_valid, obs_busy, obs_ready);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  v;
        logic [15:0] a;
        logic        h;
        do_reset();
        v = '0;
        a = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (v[i] && !exp_ready[i] && c > 0) begin
                    if ($urandom_range(9) == 0) v[i] = 1'b0;  // withdraw
                end else begin
                    v[i] = 1'($urandom_range(1));
                    a[i*4 +: 4] = 4'($urandom_range(15));
                end
            end
            h = ($urandom_range(6) == 0);
            cycle(v, a, h);
            checks += 5;
            if (obs_ready !== exp_ready) begin
                failures++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, obs_ready, exp_ready);
            end
            if (obs_rsp_valid !== exp_rsp_valid) begin
                failures++;
                $display("FAIL rand_rsp_valid c=%0d got=%b exp=%b", c, obs_rsp_valid, exp_rsp_valid);
            end
            if (obs_rsp_data !== exp_rsp_data) begin
                failures++;
                $display("FAIL rand_rsp_data c=%0d got=%h exp=%h", c, obs_rsp_data, exp_rsp_data);
            end
            if (obs_busy !== exp_busy) begin
                failures++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, obs_busy, exp_busy);
            end
            if (obs_mux_sel !== exp_mux_sel) begin
                failures++;
                $display("FAIL rand_mux_sel c=%0d got=%h exp=%h", c, obs_mux_sel, exp_mux_sel);
            end
        end
    endtask

    initial begin
        exp_ready = '0;
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_wrap_skip();
        test_hold();
        test_async_reset();
        test_withdrawn();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_read_arbiter.md
Name: rf_read_arbiter

Overview:
- Shares the single 16-entry x 32-bit register read mux (MUX16X32: sel S[3:0] in, Y[31:0] out) among up to four requesters, e.g. decode operand A, operand B, debug port, exception unit.
- Grants round-robin with a valid/ready request handshake and drives the mux select from a register.
- Samples mux output one cycle later and returns it to the granted requester with a one-cycle response pulse.
- Sits between requesting units and the register-file read mux.

Parameters:
- N_REQ, 4, number of requesters (design and verification target is 4; power of two, at most 4)
- AW, 4, address width, equals mux select width
- DW, 32, data width, equals mux Y width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester read request
- req_addr  in  N_REQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_ready  out  N_REQ  one-hot grant, combinational
- hold  in  1  pipeline stall from CPU; blocks new grants only
- mux_sel  out  AW  to MUX16X32 S, registered
- mux_y  in  DW  from MUX16X32 Y
- rsp_valid  out  N_REQ  one-hot response strobe, registered
- rsp_data  out  DW  registered read data
- busy  out  1  any stage occupied

Behaviour:
- Reset (rst_n=0, async): mux_sel=0, rsp_valid=0, rsp_data=0, rr_ptr=0, stage A/B valid=0, busy=0; req_ready=0 while rst_n=0.
- Arbitration (combinational):
  - If hold=0 and any req_valid: grant the first set bit scanning from rr_ptr upward, wrapping modulo N_REQ.
  - req_ready is one-hot on the winner, else all zero.
  - At most one grant per cycle.
- Accept edge T (req_valid[i] & req_ready[i]):
  - Stage A: a_vld<=1, a_id<=i, mux_sel<=req_addr[i].
  - rr_ptr<=(i+1) mod N_REQ.
  - No accept: a_vld<=0, mux_sel holds its last value (no toggling), rr_ptr unchanged.
- Edge T+1 (stage B):
  - If a_vld: rsp_data<=mux_y, rsp_valid<=one-hot(a_id).
  - Else rsp_valid<=0, rsp_data holds.
- Latency and throughput:
  - Response visible in the cycle after edge T+1, high for exactly one cycle.
  - Fully pipelined, one accept per cycle; back-to-back accepts give back-to-back responses in accept order.
- hold=1: req_ready=0, no new accept. An in-flight stage A entry still completes and pulses rsp_valid exactly once. No response is lost or duplicated across hold edges.
- Requesters must keep req_valid and req_addr stable until ready; a drop without ready is legal (request withdrawn, no response).
- Same requester may be granted on consecutive cycles only if it is the sole requester.
- busy = a_vld | (rsp_valid != 0).
- Reset mid-operation: all in-flight entries discarded, no rsp_valid after release; first post-reset grant starts scanning at requester 0.
- No response backpressure: the requester must consume rsp_data in the rsp_valid cycle.
- Address 0 is not special here; the zero-register convention is the register file's concern.

Test Plan:
- Single request: reset, req_valid=4'b0001, addr0=4'h5, mux model Y=sel*32'h11111111 -> req_ready=0001 at T; mux_sel=5 after T; rsp_valid=0001, rsp_data=32'h55555555 in cycle after T+1; busy clears next cycle.
- Round-robin fairness: all four requesters held valid, addrs 1,2,3,4 -> grants 0,1,2,3,0,... one per cycle; responses 0x11111111, 0x22222222, ... consecutive, each rsp_valid one-hot matching its grant.
- Pointer wrap and skip: rr_ptr=3, req_valid=0101 -> grant requester 0, then requester 2, then 0; grant never goes to a non-requesting index.
- Hold: accept requester 1 at T, assert hold at T+1 for 3 cycles with all req_valid=1 -> exactly one rsp_valid=0010, req_ready=0 during hold, mux_sel stable; grants resume from rr_ptr=2 when hold drops.
- Async reset mid-flight: accept at T, pulse rst_n low between edges before T+1 -> rsp_valid never asserts, mux_sel=0 immediately, next grant starts at requester 0.
- Withdrawn request: req_valid[2] pulses 1 cycle while hold=1 -> no grant, no response, busy stays 0.
